// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit adder among N_REQ requesters.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_valid/ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b    : packed 8-bit operands, requester i at [8i+7:8i]
//   rsp_valid/ready : result handshake
//   rsp_sum/cout/id : registered sum, carry-out and owning requester
//   grant_cnt       : saturating count of accepted requests

module adder_8b_5l (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // Kogge-Stone prefix tree: gp, three prefix levels, sum.
    logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [8:0] c;

    assign g0 = a & b;
    assign p0 = a ^ b;

    always_comb begin
        g1 = g0;
        p1 = p0;
        for (int i = 1; i < 8; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end
    end

    always_comb begin
        g2 = g1;
        p2 = p1;
        for (int i = 2; i < 8; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end
    end

    always_comb begin
        g3 = g2;
        p3 = p2;
        for (int i = 4; i < 8; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
            p3[i] = p2[i] & p2[i-4];
        end
    end

    always_comb begin
        c = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g3[i] | (p3[i] & cin);
        end
    end

    assign sum  = p0 ^ c[7:0];
    assign cout = c[8];

endmodule

module adder_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_sum,
    output logic               rsp_cout,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        grant_cnt
);

    logic [IDW-1:0]   last_grant;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   win;
    logic             found;
    logic             slot_free;
    logic             transfer;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [7:0]       add_sum;
    logic             add_cout;
    int               start;

    assign slot_free = !rsp_valid || rsp_ready;

    // Search begins one past the last winner; first valid found wins.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        start = (int'(last_grant) + 1) % N_REQ;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(start + k) % N_REQ]) begin
                found = 1'b1;
                grant[(start + k) % N_REQ] = 1'b1;
                win = IDW'((start + k) % N_REQ);
            end
        end
    end

    // rst_n gates grants so nothing is accepted while reset is held.
    assign req_ready = (found && slot_free && rst_n) ? grant : '0;
    assign transfer  = |req_ready;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDW'(i)) begin
                op_a = req_a[i*8 +: 8];
                op_b = req_b[i*8 +: 8];
            end
        end
    end

    adder_8b_5l u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= '0;
            last_grant <= IDW'(N_REQ - 1);
        end else if (transfer) begin
            rsp_valid  <= 1'b1;
            rsp_sum    <= add_sum;
            rsp_cout   <= add_cout;
            rsp_id     <= win;
            last_grant <= win;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (transfer && grant_cnt != 16'hFFFF) begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end

endmodule
